// File: rtl/ifetch_prefetch_queue_if.sv
// Fetch-side bundle: instruction memory request/response, redirect input and
// the queue head presented to IF/ID.
interface ifetch_prefetch_queue_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
);
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               req_valid;
  logic [ADDR_W-1:0]  req_addr;
  logic               req_ready;
  logic               resp_valid;
  logic [INSTR_W-1:0] resp_data;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               out_ready;

  modport master (
    output redirect, redirect_pc, req_ready, resp_valid, resp_data, out_ready,
    input  req_valid, req_addr, out_valid, out_instr, out_pc
  );

  modport slave (
    input  redirect, redirect_pc, req_ready, resp_valid, resp_data, out_ready,
    output req_valid, req_addr, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/ifetch_prefetch_queue.sv
// Instruction prefetch queue: one outstanding sequential fetch, DEPTH-entry FIFO,
// flush on redirect. Define IFQ_STATS_EN to add flush/stall counters.
//
// state | meaning
// IDLE  | may issue a fetch when the FIFO has room
// WAIT  | one live request outstanding; response is pushed
// DRAIN | one stale request outstanding; response is dropped
module ifetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 64,
  parameter int          INSTR_W  = 32,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic clk,
  input  logic rst,
  ifetch_prefetch_queue_if.slave bus
`ifdef IFQ_STATS_EN
  ,
  output logic [31:0] stat_flush_cnt,
  output logic [31:0] stat_stall_cnt
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [INSTR_W-1:0] NOP = INSTR_W'(32'h0000_0013);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  req_pc;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic full;
  logic issue;
  logic push;
  logic pop;

  assign full  = (count == CNT_W'(DEPTH));
  // rst gate keeps req_valid low while reset is held, not just after it
  assign bus.req_valid = !rst && (state == IDLE) && !full && !bus.redirect;
  assign bus.req_addr  = fetch_pc;
  assign issue = bus.req_valid && bus.req_ready;
  assign push  = (state == WAIT) && bus.resp_valid && !bus.redirect;
  assign pop   = bus.out_valid && bus.out_ready && !bus.redirect;

  assign bus.out_valid = (count != '0);
  assign bus.out_instr = bus.out_valid ? instr_mem[rd_ptr] : NOP;
  assign bus.out_pc    = bus.out_valid ? pc_mem[rd_ptr]    : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC[ADDR_W-1:0];
      req_pc   <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (bus.redirect) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fetch_pc <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      case (state)
        IDLE:    state <= IDLE;
        default: state <= bus.resp_valid ? IDLE : DRAIN;
      endcase
    end else begin
      case (state)
        IDLE: if (issue) begin
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + ADDR_W'(4);
          state    <= WAIT;
        end
        WAIT:    if (bus.resp_valid) state <= IDLE;
        DRAIN:   if (bus.resp_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: it is only observed while count is nonzero
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= req_pc;
      instr_mem[wr_ptr] <= bus.resp_data;
    end
  end

`ifdef IFQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_flush_cnt <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (bus.redirect && !(&stat_flush_cnt))
        stat_flush_cnt <= stat_flush_cnt + 32'd1;
      if (bus.out_ready && !bus.out_valid && !bus.redirect && !(&stat_stall_cnt))
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif
endmodule
